// File: rtl/prime_gen_pkg.sv
// Shared types and constants for the prime pair generator slice.
package prime_gen_pkg;

  localparam int unsigned PG_WIDTH = 8;

  // Galois LFSR feedback mask
  localparam logic [PG_WIDTH-1:0] PG_TAPS = 8'hB8;

  // Forces candidates odd and into the upper half of the range
  localparam logic [PG_WIDTH-1:0] PG_CAND_MASK = 8'h81;

  typedef enum logic [1:0] {
    PG_IDLE,
    PG_GEN,
    PG_ISSUE,
    PG_WAIT
  } pg_state_t;

endpackage

// File: rtl/prime_lfsr.sv
// Galois LFSR candidate source. A zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module prime_lfsr
  import prime_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = PG_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = PG_TAPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_next;

  // One Galois step: shift right, fold the taps in when a 1 falls out
  always_comb begin
    value_next = (value >> 1) ^ (value[0] ? TAPS : '0);
  end

  // Seed load has priority over stepping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= WIDTH'(1);
    end else if (load) begin
      value <= (seed == '0) ? WIDTH'(1) : seed;
    end else if (step) begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/prime_pair_gen.sv
// Candidate generator feeding the primality checker; returns two distinct
// primes p and q, or pulses fail once MAX_TRIES candidates were rejected.
// Optional macro PRIME_PAIR_GEN_ASSUME_EN: also accept the checker's
// probable-prime flag (chk_assume_prime) as a prime verdict.
// The attached checker is expected to take its rst_n from ~rst.
module prime_pair_gen
  import prime_gen_pkg::*;
#(
  parameter int unsigned      WIDTH     = PG_WIDTH,
  parameter int unsigned      MAX_TRIES = 64,
  parameter logic [WIDTH-1:0] TAPS      = PG_TAPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic             chk_start,
  output logic [WIDTH-1:0] chk_num,
  input  logic             chk_finish,
  input  logic             chk_is_prime,
  input  logic             chk_assume_prime,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             fail
);

  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  pg_state_t        state, state_next;
  logic [TW-1:0]    tries;
  logic             have_p;
  logic [WIDTH-1:0] lfsr_val;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] cand;
  logic             verdict;
  logic             accept;
  logic             at_limit;

  prime_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (seed_load && (state == PG_IDLE)),
    .seed  (seed),
    .step  (state == PG_GEN),
    .value (lfsr_val)
  );

`ifdef PRIME_PAIR_GEN_ASSUME_EN
  // Probable primes from the checker's early exit count as primes
  always_comb begin
    verdict = chk_is_prime | chk_assume_prime;
  end
`else
  logic unused_assume;

  // Only a definite prime verdict is trusted
  always_comb begin
    verdict       = chk_is_prime;
    unused_assume = chk_assume_prime;
  end
`endif

  // Candidate preview, acceptance and try-limit decode
  always_comb begin
    lfsr_next = (lfsr_val >> 1) ^ (lfsr_val[0] ? TAPS : '0);
    accept    = verdict && (!have_p || (cand != p));
    at_limit  = (tries == TW'(MAX_TRIES));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PG_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      PG_IDLE:  if (start) state_next = PG_GEN;
      PG_GEN:   state_next = PG_ISSUE;
      PG_ISSUE: state_next = PG_WAIT;
      PG_WAIT: begin
        if (chk_finish) begin
          if (accept) begin
            state_next = have_p ? PG_IDLE : PG_GEN;
          end else begin
            state_next = at_limit ? PG_IDLE : PG_GEN;
          end
        end
      end
      default:  state_next = PG_IDLE;
    endcase
  end

  // Moore outputs; chk_start follows the async-reset state directly
  always_comb begin
    chk_start = (state == PG_ISSUE);
    busy      = (state != PG_IDLE);
    chk_num   = cand;
  end

  // Try counter, candidate and result registers, done/fail pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tries  <= '0;
      have_p <= 1'b0;
      cand   <= '0;
      p      <= '0;
      q      <= '0;
      done   <= 1'b0;
      fail   <= 1'b0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      unique case (state)
        PG_IDLE: begin
          if (start) begin
            tries  <= '0;
            have_p <= 1'b0;
          end
        end
        PG_GEN: cand <= lfsr_next | WIDTH'(PG_CAND_MASK);
        PG_ISSUE: begin
          if (!at_limit) tries <= tries + 1'b1;
        end
        PG_WAIT: begin
          if (chk_finish) begin
            if (accept) begin
              if (!have_p) begin
                p      <= cand;
                have_p <= 1'b1;
              end else begin
                q    <= cand;
                done <= 1'b1;
              end
            end else if (at_limit) begin
              fail <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_pair_gen.sv
// Self-checking bench for prime_pair_gen: a behavioural checker answers
// each chk_start after a programmable latency, and a high-level model
// predicts candidates, p/q and the try count for every request.
module tb_prime_pair_gen;

`ifdef PRIME_PAIR_GEN_ASSUME_EN
  localparam bit ASSUME_EN = 1'b1;
`else
  localparam bit ASSUME_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, seed_load = 1'b0;
  logic [7:0] seed = '0;
  logic       chk_start, chk_finish;
  logic [7:0] chk_num, p, q;
  logic       chk_is_prime = 1'b0, chk_assume_prime = 1'b0;
  logic       busy, done, fail;
  logic       rsp_fin = 1'b0, tb_fin = 1'b0;

  logic       s_start = 1'b0;
  logic       s_chk_start, s_chk_finish = 1'b0;
  logic [7:0] s_chk_num, s_p, s_q;
  logic       s_zero = 1'b0;
  logic       s_busy, s_done, s_fail;

  int unsigned checks = 0, passed = 0, failed = 0;
  int          rsp_mode = 0, rsp_lat = 5, rsp_cnt = 0, s_cnt = 0;
  logic [7:0]  rsp_num = '0;
  byte unsigned issued[$];
  int unsigned exp_cands[$];
  int unsigned n_starts = 0, s_starts = 0;
  int unsigned exp_p = 0, exp_q = 0, ref_lfsr = 1;

  assign chk_finish = rsp_fin | tb_fin;

  always #5 clk = ~clk;

  prime_pair_gen dut (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
    .chk_start(chk_start), .chk_num(chk_num), .chk_finish(chk_finish),
    .chk_is_prime(chk_is_prime), .chk_assume_prime(chk_assume_prime),
    .p(p), .q(q), .busy(busy), .done(done), .fail(fail)
  );

  prime_pair_gen #(.MAX_TRIES(4)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .seed_load(seed_load), .seed(seed),
    .chk_start(s_chk_start), .chk_num(s_chk_num), .chk_finish(s_chk_finish),
    .chk_is_prime(s_zero), .chk_assume_prime(s_zero),
    .p(s_p), .q(s_q), .busy(s_busy), .done(s_done), .fail(s_fail)
  );

  function automatic bit is_prime(input int unsigned n);
    if (n < 2) return 1'b0;
    for (int unsigned d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Checker behaviour: 0 truthful, 1 all prime, 2 none prime, 3 185 only "probable"
  function automatic void verdict_of(input int unsigned n, input int mode,
                                     output bit pr, output bit as);
    pr = 1'b0;
    as = 1'b0;
    case (mode)
      0: pr = is_prime(n);
      1: pr = 1'b1;
      2: pr = 1'b0;
      default: if (n == 185) as = 1'b1; else pr = is_prime(n);
    endcase
  endfunction

  // Reference: walk the candidate stream and apply the acceptance rules
  function automatic void model(input int unsigned seed0, input int mode,
                                input int unsigned max_tries,
                                inout int unsigned ep, inout int unsigned eq,
                                output bit ok, output int unsigned nt,
                                output int unsigned lfsr_end);
    int unsigned l, c;
    bit have, pr, as;
    l = (seed0 == 0) ? 1 : seed0;
    have = 1'b0;
    ok = 1'b0;
    nt = 0;
    exp_cands.delete();
    while (nt < max_tries) begin
      l = (l >> 1) ^ (((l & 1) != 0) ? 32'hB8 : 32'h0);
      c = l | 32'h81;
      exp_cands.push_back(c);
      nt++;
      verdict_of(c, mode, pr, as);
      if ((pr || (ASSUME_EN && as)) && (!have || c != ep)) begin
        if (!have) begin
          ep = c;
          have = 1'b1;
        end else begin
          eq = c;
          ok = 1'b1;
          break;
        end
      end
    end
    lfsr_end = l;
  endfunction

  // Main checker: records each issued candidate, answers after rsp_lat cycles
  always @(negedge clk or posedge rst) begin
    bit pr, as;
    if (rst) begin
      rsp_cnt = 0;
      rsp_fin = 1'b0;
      chk_is_prime = 1'b0;
      chk_assume_prime = 1'b0;
    end else begin
      rsp_fin = 1'b0;
      chk_is_prime = 1'b0;
      chk_assume_prime = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          verdict_of(rsp_num, rsp_mode, pr, as);
          rsp_fin = 1'b1;
          chk_is_prime = pr;
          chk_assume_prime = as;
        end
      end
      if (chk_start) begin
        issued.push_back(chk_num);
        n_starts++;
        rsp_num = chk_num;
        rsp_cnt = rsp_lat;
      end
    end
  end

  // Small-instance checker: always answers not-prime after 3 cycles
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      s_cnt = 0;
      s_chk_finish = 1'b0;
    end else begin
      s_chk_finish = 1'b0;
      if (s_cnt > 0) begin
        s_cnt--;
        if (s_cnt == 0) s_chk_finish = 1'b1;
      end
      if (s_chk_start) begin
        s_starts++;
        s_cnt = 3;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_pair(input string tag, input bit do_load, input logic [7:0] sd,
                          input int mode, input int lat, input bit poke);
    int unsigned ep, eq, nt, le, s0, mism;
    bit ok, got, poked;
    ep = exp_p;
    eq = exp_q;
    s0 = do_load ? 32'(sd) : ref_lfsr;
    model(s0, mode, 64, ep, eq, ok, nt, le);
    rsp_mode = mode;
    rsp_lat = lat;
    issued.delete();
    n_starts = 0;
    @(negedge clk);
    seed = sd;
    seed_load = do_load;
    start = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b0;
    check({tag, "_gen"}, {busy, chk_start}, 2'b10);
    @(negedge clk);
    check({tag, "_issue_lat"}, chk_start, 1'b1);
    got = 1'b0;
    poked = 1'b0;
    for (int i = 0; i < 64 * (lat + 4) + 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done || fail) begin
        got = 1'b1;
        break;
      end
      if (poke && !poked && n_starts == 1 && !chk_start) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    check({tag, "_finished"}, got, 1'b1);
    check({tag, "_done_fail"}, {done, fail, busy}, {ok, !ok, 1'b0});
    check({tag, "_p"}, p, ep);
    check({tag, "_q"}, q, eq);
    check({tag, "_tries"}, n_starts, nt);
    mism = (issued.size() == exp_cands.size()) ? 0 : 1;
    for (int i = 0; i < issued.size() && i < exp_cands.size(); i++)
      if (32'(issued[i]) != exp_cands[i]) mism++;
    check({tag, "_cand_seq"}, mism, 0);
    @(negedge clk);
    check({tag, "_pulse_end"}, {done, fail, busy}, 3'b000);
    exp_p = ep;
    exp_q = eq;
    ref_lfsr = le;
  endtask

  initial begin
    bit got, s_done_seen;
    int unsigned first, pp, qq;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", {chk_start, busy, done, fail}, 4'b0000);
    check("rst_pq", {p, q, chk_num}, 24'h0);
    rst = 1'b0;

    // Directed: seed 1, truthful checker, latency 5
    run_pair("seed1", 1'b1, 8'h01, 0, 5, 1'b0);
    check("seed1_p_const", p, 151);
    check("seed1_q_const", q, 179);
    check("seed1_tries_const", n_starts, 5);
    first = (issued.size() >= 3) ? {issued[0], issued[1], issued[2]} : 0;
    check("seed1_first3", first, {8'd185, 8'd221, 8'd175});

    // Small instance: always rejected, limit 4
    s_starts = 0;
    s_done_seen = 1'b0;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_done) s_done_seen = 1'b1;
      if (s_fail) begin
        got = 1'b1;
        break;
      end
    end
    check("small_fail_seen", got, 1'b1);
    check("small_starts", s_starts, 4);
    check("small_pq", {s_p, s_q, 7'b0, s_done_seen}, 24'h0);
    @(negedge clk);
    check("small_idle", {s_busy, s_fail}, 2'b00);

    // All candidates prime: q must differ from p
    run_pair("allprime", 1'b1, 8'($urandom_range(255)), 1, 2, 1'b0);
    check("allprime_distinct", p != q, 1'b1);

    // All rejected at full limit: p and q keep their values
    pp = p;
    qq = q;
    run_pair("allreject", 1'b0, 8'h00, 2, 1, 1'b0);
    check("allreject_64", n_starts, 64);
    check("allreject_pq_kept", {p, q}, {pp[7:0], qq[7:0]});

    // chk_finish in IDLE is ignored
    @(negedge clk);
    tb_fin = 1'b1;
    @(negedge clk);
    tb_fin = 1'b0;
    check("idle_finish", {busy, done, fail, p, q}, {3'b000, pp[7:0], qq[7:0]});
    @(negedge clk);
    check("idle_finish_later", {busy, done, fail}, 3'b000);

    // start during WAIT is ignored; LFSR continues where it stopped
    run_pair("poke", 1'b0, 8'h00, 0, 5, 1'b1);

    // Probable-prime flag on 185 from seed 1 (seed 0 maps to 1)
    run_pair("assume", 1'b1, 8'h00, 3, 3, 1'b0);
    check("assume_p_const", p, ASSUME_EN ? 185 : 151);

    // Randomized requests
    for (int k = 0; k < 10; k++)
      run_pair("rand", 1'($urandom_range(1)), 8'($urandom),
               int'($urandom_range(1)), int'($urandom_range(1, 6)), 1'($urandom_range(1)));

    // Async reset in ISSUE drops chk_start immediately
    @(negedge clk);
    seed = 8'h5A;
    seed_load = 1'b1;
    start = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_issue", chk_start, 1'b1);
    #1 rst = 1'b1;
    #1 check("async_rst_issue", {chk_start, busy}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Reset in WAIT after two candidates
    rsp_mode = 0;
    rsp_lat = 4;
    n_starts = 0;
    @(negedge clk);
    seed = 8'($urandom);
    seed_load = 1'b1;
    start = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_starts >= 2 && !chk_start) begin
        got = 1'b1;
        break;
      end
    end
    check("wait_two_cands", got, 1'b1);
    check("wait_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 check("rst_wait_ctrl", {busy, chk_start, done, fail}, 4'b0000);
    check("rst_wait_data", {p, q, chk_num}, 24'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_p = 0;
    exp_q = 0;
    ref_lfsr = 1;

    // After reset the search restarts from LFSR 8'h01
    run_pair("post_rst", 1'b0, 8'h00, 0, 2, 1'b0);
    first = (issued.size() > 0) ? 32'(issued[0]) : 0;
    check("post_rst_first", first, 185);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/prime_pair_gen.md
# prime_pair_gen

Upstream candidate generator for the primality checker in the RSA key-generation path. Draws pseudo-random odd 8-bit candidates from an LFSR, launches one check per candidate on the checker's start/num handshake, consumes its finish/IsPrime result, and returns two distinct primes p and q to key generation. A try limit bounds the search; when it is exhausted the block reports failure.

## Interface
- `WIDTH`, 8: candidate and prime width; the checker's num width.
- `MAX_TRIES`, 64: maximum number of candidates issued per pair request.
- `TAPS`, 8'hB8: Galois LFSR feedback mask.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset; it clears all state immediately. The top level drives the checker's `rst_n` as `~rst`.
- `start` in 1: one-cycle request for a new p/q pair; accepted only in IDLE.
- `seed_load` in 1: loads `seed` into the LFSR; honoured only in IDLE.
- `seed` in WIDTH: LFSR seed. A value of 0 is replaced by 1.
- `chk_start` out 1: one-cycle start pulse to the checker.
- `chk_num` out WIDTH: candidate under test, held stable from ISSUE until the verdict.
- `chk_finish` in 1: checker verdict valid.
- `chk_is_prime` in 1: checker verdict.
- `chk_assume_prime` in 1: checker probable-prime flag; used only under the macro.
- `p`, `q` out WIDTH: result primes, held until the next accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; p and q are valid.
- `fail` out 1: one-cycle pulse; the try limit was exhausted.

## Operation
- States: IDLE, GEN, ISSUE, WAIT.
- IDLE → GEN on `start`. This transition clears `tries` and `have_p`.
- GEN: the LFSR steps once and the candidate register latches `lfsr_next | 8'h81`, so every candidate is odd and in the range 129..255.
- LFSR step: `lsb = l[0]`, `l = l >> 1`, and if `lsb` is 1, `l ^= TAPS`.
- ISSUE: `chk_start` is 1 and `tries` increments. Next state is WAIT.
- WAIT: holds until `chk_finish`. The verdict is evaluated in the same cycle.
  - Accept when `chk_is_prime` is 1 and either `have_p` is 0 or the candidate differs from `p`.
  - If accepted and `have_p` is 0: store p, set `have_p`, go to GEN.
  - If accepted and `have_p` is 1: store q, pulse `done`, go to IDLE.
  - If rejected and `tries` equals MAX_TRIES: pulse `fail`, go to IDLE. p and q keep their old values.
  - Otherwise, if rejected: go to GEN.
- `tries` width is `$clog2(MAX_TRIES+1)`; it never wraps.
- A `start` while busy is ignored. A `chk_finish` outside WAIT is ignored.
- In IDLE, `seed_load` and `start` may arrive in the same cycle. The seed loads first and the first GEN steps from the new seed.

## Timing
- Reset values: all outputs are 0. The LFSR resets to 8'h01 and the state to IDLE.
- Reset mid-search: the block returns to IDLE immediately and `chk_start` drops asynchronously.
- `start` to first `chk_start`: 2 cycles (GEN, ISSUE).
- Per-candidate cost: 2 cycles plus the checker latency. `chk_finish` to the next `chk_start` is 2 cycles.
- `done` and `fail` assert in the cycle after `chk_finish` is sampled, registered alongside the state change.
- `chk_num` is valid in the `chk_start` cycle and stays valid through `chk_finish`.

## Configuration
- `PRIME_PAIR_GEN_ASSUME_EN` defined: the accept condition uses `chk_is_prime | chk_assume_prime`. This accepts probable primes from the checker's early-exit path.
- Undefined: only `chk_is_prime` is used and `chk_assume_prime` is unconnected internally.

## Structure
- `prime_gen_pkg` holds:
  - the state enum `pg_state_t`;
  - `PG_WIDTH`;
  - `PG_TAPS`;
  - the candidate OR-mask `PG_CAND_MASK = 8'h81`.
- One sub-module, `prime_lfsr` (Galois LFSR), with ports `clk`, `rst`, `load`, `seed`, `step`, `value`. The FSM, try counter and result registers stay in `prime_pair_gen`.

## Test plan
- Seed 8'h01 and `start`, with a bench checker that answers truthfully after 5 cycles. Candidates must be 185, 221, 175, 151, 179. Expected result: p=151, q=179, `done` pulse, `tries`=5.
- The bench checker reports every candidate prime. The second candidate must differ from p. Expected: q equals the second candidate and `done` follows 2 checks.
- The bench checker always answers not-prime with MAX_TRIES=4. Expected: exactly 4 `chk_start` pulses, then a `fail` pulse, with p and q unchanged from the previous run.
- Assert `rst` during WAIT after 2 candidates. Expected: `busy` and `chk_start` drop immediately, outputs read 0, and the next `start` runs from LFSR 8'h01.
- `start` pulsed during WAIT, and `chk_finish` pulsed in IDLE. Expected: no effect on the state, `tries` or outputs.
- With `PRIME_PAIR_GEN_ASSUME_EN` and the checker returning `chk_assume_prime`=1, `chk_is_prime`=0 on 185: p=185 is accepted. Without the macro, 185 is rejected.
